// File: rtl/pl_fetch_ctrl.sv
// Instruction fetch controller: PC sequencing with branch redirect, stall hold and halt detection.
// Define FETCH_PERF_CNT_EN to build the saturating fetch/flush performance counters.
module pl_fetch_ctrl #(
  parameter int unsigned             PROG_CTR_WID = 10,
  parameter logic [PROG_CTR_WID-1:0] RESET_VECTOR = '0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    stall_in,
  input  logic                    branch_taken_EX,
  input  logic [PROG_CTR_WID-1:0] branch_target,
  input  logic [15:0]             instr_mem_out,
  output logic [PROG_CTR_WID-1:0] instr_mem_addr,
  output logic                    instr_mem_rd_en,
  output logic [PROG_CTR_WID-1:0] fetch_pc,
  output logic                    fetch_valid,
  output logic                    halted,
  output logic                    pc_wrapped,
  output logic [15:0]             fetch_cnt,
  output logic [7:0]              flush_cnt
);

  typedef enum logic [1:0] {RESET_WAIT, RUN, STALL, HALT} state_t;

  state_t                  state_q, state_d;
  logic [PROG_CTR_WID-1:0] pc_q, pc_d;
  logic [PROG_CTR_WID-1:0] fetch_pc_q, fetch_pc_d;
  logic                    fetch_valid_q, fetch_valid_d;
  logic                    wrapped_q, wrapped_d;
  logic                    halt_det;
  logic                    unused_instr_bits;

  assign halt_det          = fetch_valid_q && (instr_mem_out[15:11] == 5'b11111);
  assign unused_instr_bits = ^instr_mem_out[10:0];

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_pc_d    = fetch_pc_q;
    fetch_valid_d = fetch_valid_q;
    wrapped_d     = wrapped_q;
    case (state_q)
      RESET_WAIT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b0;
      end
      default: begin
        if (branch_taken_EX) begin
          // Redirect wins over everything, including a halt opcode seen this cycle.
          state_d       = RUN;
          pc_d          = branch_target;
          fetch_valid_d = 1'b0;
        end else if (state_q == HALT) begin
          state_d = HALT;
        end else if (halt_det) begin
          state_d       = HALT;
          fetch_valid_d = 1'b0;
        end else if (stall_in) begin
          state_d = STALL;
        end else begin
          state_d       = RUN;
          fetch_pc_d    = pc_q;
          fetch_valid_d = 1'b1;
          pc_d          = pc_q + PROG_CTR_WID'(1);
          if (pc_q == '1) wrapped_d = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= RESET_WAIT;
      pc_q          <= RESET_VECTOR;
      fetch_pc_q    <= '0;
      fetch_valid_q <= 1'b0;
      wrapped_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_pc_q    <= fetch_pc_d;
      fetch_valid_q <= fetch_valid_d;
      wrapped_q     <= wrapped_d;
    end
  end

  assign instr_mem_addr  = pc_q;
  assign instr_mem_rd_en = (state_q == RUN) || (state_q == STALL);
  assign fetch_pc        = fetch_pc_q;
  assign fetch_valid     = fetch_valid_q;
  assign halted          = (state_q == HALT);
  assign pc_wrapped      = wrapped_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_cnt_q;
  logic [7:0]  flush_cnt_q;
  logic        flush_inc;

  assign flush_inc = branch_taken_EX && (state_q != RESET_WAIT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (fetch_valid_q && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      if (flush_inc && (flush_cnt_q != '1))     flush_cnt_q <= flush_cnt_q + 8'd1;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign fetch_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pl_fetch_ctrl.sv
// Bench for pl_fetch_ctrl: directed scenarios plus randomized traffic against a behavioural model.
// Counter expectations follow FETCH_PERF_CNT_EN when it is defined for the build.
module tb_pl_fetch_ctrl;
  localparam int W = 10;
`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          stall_in = 1'b0;
  logic          branch_taken_EX = 1'b0;
  logic [W-1:0]  branch_target = '0;
  logic [15:0]   instr_mem_out = '0;
  logic [W-1:0]  instr_mem_addr;
  logic          instr_mem_rd_en;
  logic [W-1:0]  fetch_pc;
  logic          fetch_valid;
  logic          halted;
  logic          pc_wrapped;
  logic [15:0]   fetch_cnt;
  logic [7:0]    flush_cnt;

  int n_pass = 0;
  int n_tot  = 0;

  pl_fetch_ctrl #(.PROG_CTR_WID(W), .RESET_VECTOR(10'h000)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .branch_taken_EX(branch_taken_EX),
    .branch_target(branch_target), .instr_mem_out(instr_mem_out),
    .instr_mem_addr(instr_mem_addr), .instr_mem_rd_en(instr_mem_rd_en),
    .fetch_pc(fetch_pc), .fetch_valid(fetch_valid), .halted(halted),
    .pc_wrapped(pc_wrapped), .fetch_cnt(fetch_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous instruction memory, one-cycle read latency.
  logic [15:0] mem [0:1023];
  always @(posedge clk) if (instr_mem_rd_en) instr_mem_out <= mem[instr_mem_addr];

  // Behavioural model: what the fetch stream should look like, cycle by cycle.
  bit           m_run, m_halt, m_valid, m_wrap, m_det;
  logic [W-1:0] m_pc, m_fpc;
  logic [15:0]  m_word;
  int           m_fcnt, m_flcnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_run = 0; m_halt = 0; m_valid = 0; m_wrap = 0;
      m_pc = '0; m_fpc = '0; m_word = '0; m_fcnt = 0; m_flcnt = 0;
    end else begin
      m_det = m_valid && (m_word[15:11] == 5'h1f);
      if (m_valid && m_fcnt < 65535) m_fcnt++;
      if (m_run && !m_halt) m_word = mem[m_pc];
      if (!m_run) m_run = 1;
      else if (branch_taken_EX) begin
        m_pc = branch_target; m_valid = 0; m_halt = 0;
        if (m_flcnt < 255) m_flcnt++;
      end else if (m_halt) ;
      else if (m_det) begin m_halt = 1; m_valid = 0; end
      else if (stall_in) ;
      else begin
        m_fpc = m_pc; m_valid = 1;
        if (m_pc == 10'h3FF) m_wrap = 1;
        m_pc = m_pc + 10'd1;
      end
    end
  end

  task automatic tick(input logic br, input logic [W-1:0] tgt, input logic st);
    branch_taken_EX = br; branch_target = tgt; stall_in = st;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    branch_taken_EX = 0; stall_in = 0; rst = 0;
    @(posedge clk); #1;
    rst = 1;
  endtask

  task automatic fill_mem(input int halt_pct);
    for (int i = 0; i < 1024; i++)
      mem[i] = ($urandom_range(99) < halt_pct) ? {5'h1f, 11'($urandom)} : (16'($urandom) & 16'h7FFF);
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_addr [4];
    exp_addr = '{10'd0, 10'd1, 10'd2, 10'd3};
    fill_mem(0);
    #2 rst = 0; #1;
    n_tot++; if ({instr_mem_addr, fetch_pc} !== 20'h0) $display("FAIL rst_addr_pc: got %h/%h want 0/0", instr_mem_addr, fetch_pc); else n_pass++;
    n_tot++; if ({instr_mem_rd_en, fetch_valid, halted, pc_wrapped} !== 4'b0) $display("FAIL rst_flags: got %b want 0000", {instr_mem_rd_en, fetch_valid, halted, pc_wrapped}); else n_pass++;
    n_tot++; if ({fetch_cnt, flush_cnt} !== 24'h0) $display("FAIL rst_cnt: got %h/%h want 0/0", fetch_cnt, flush_cnt); else n_pass++;
    @(posedge clk); @(posedge clk); #1 rst = 1;
    n_tot++; if (instr_mem_rd_en !== 1'b0) $display("FAIL reset_wait_rden: got %b want 0", instr_mem_rd_en); else n_pass++;
    for (int c = 1; c <= 4; c++) begin
      tick(0, '0, 0);
      n_tot++; if (instr_mem_addr !== exp_addr[c-1]) $display("FAIL start_addr c%0d: got %h want %h", c, instr_mem_addr, exp_addr[c-1]); else n_pass++;
      n_tot++; if ({instr_mem_rd_en, fetch_valid} !== {1'b1, c >= 2}) $display("FAIL start_rden_valid c%0d: got %b%b want 1%b", c, instr_mem_rd_en, fetch_valid, c >= 2); else n_pass++;
      if (c >= 2) begin
        n_tot++; if (fetch_pc !== W'(c - 2)) $display("FAIL start_fpc c%0d: got %h want %h", c, fetch_pc, W'(c - 2)); else n_pass++;
      end
    end
  endtask

  task automatic test_branch();
    do_reset();
    for (int i = 0; i < 40 && instr_mem_addr != 10'h010; i++) tick(0, '0, 0);
    n_tot++; if (instr_mem_addr !== 10'h010) $display("FAIL br_reach: got %h want 010", instr_mem_addr); else n_pass++;
    tick(1, 10'h155, 0);
    n_tot++; if ({instr_mem_addr, fetch_valid} !== {10'h155, 1'b0}) $display("FAIL br_redirect: got %h/%b want 155/0", instr_mem_addr, fetch_valid); else n_pass++;
    n_tot++; if (flush_cnt !== (PERF ? 8'd1 : 8'd0)) $display("FAIL br_flush_cnt: got %0d want %0d", flush_cnt, PERF ? 1 : 0); else n_pass++;
    tick(0, '0, 0);
    n_tot++; if ({instr_mem_addr, fetch_pc, fetch_valid} !== {10'h156, 10'h155, 1'b1}) $display("FAIL br_resume: got %h/%h/%b want 156/155/1", instr_mem_addr, fetch_pc, fetch_valid); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    for (int i = 0; i < 20 && instr_mem_addr != 10'h005; i++) tick(0, '0, 0);
    for (int c = 0; c < 3; c++) begin
      tick(0, '0, 1);
      n_tot++; if ({instr_mem_addr, instr_mem_rd_en, fetch_pc, fetch_valid} !== {10'h005, 1'b1, 10'h004, 1'b1}) $display("FAIL stall_hold c%0d: got %h/%b/%h/%b want 005/1/004/1", c, instr_mem_addr, instr_mem_rd_en, fetch_pc, fetch_valid); else n_pass++;
    end
    for (int c = 0; c < 2; c++) begin
      tick(0, '0, 0);
      n_tot++; if ({instr_mem_addr, fetch_pc} !== {W'(6 + c), W'(5 + c)}) $display("FAIL stall_resume c%0d: got %h/%h want %h/%h", c, instr_mem_addr, fetch_pc, W'(6 + c), W'(5 + c)); else n_pass++;
    end
  endtask

  task automatic test_halt();
    logic [W-1:0] frozen;
    mem[10'h030] = 16'hF800;
    do_reset();
    tick(0, '0, 0);
    tick(1, 10'h02E, 0);
    for (int i = 0; i < 10 && !halted; i++) tick(0, '0, 0);
    n_tot++; if ({halted, instr_mem_rd_en, fetch_valid, instr_mem_addr} !== {3'b100, 10'h031}) $display("FAIL halt_enter: got %b%b%b/%h want 100/031", halted, instr_mem_rd_en, fetch_valid, instr_mem_addr); else n_pass++;
    frozen = instr_mem_addr;
    for (int c = 0; c < 3; c++) begin
      tick(0, '0, c[0]);
      n_tot++; if ({halted, instr_mem_rd_en, instr_mem_addr} !== {2'b10, frozen}) $display("FAIL halt_frozen c%0d: got %b%b/%h want 10/%h", c, halted, instr_mem_rd_en, instr_mem_addr, frozen); else n_pass++;
    end
    tick(1, 10'h020, 0);
    n_tot++; if ({halted, instr_mem_rd_en, instr_mem_addr} !== {2'b01, 10'h020}) $display("FAIL halt_exit: got %b%b/%h want 01/020", halted, instr_mem_rd_en, instr_mem_addr); else n_pass++;
    mem[10'h030] = 16'h0000;
    // A halt word meeting a branch in the same cycle must be dropped.
    mem[10'h040] = 16'hF800;
    tick(1, 10'h03E, 0);
    for (int i = 0; i < 3; i++) tick(0, '0, 0);
    n_tot++; if ({fetch_pc, fetch_valid, instr_mem_out[15:11]} !== {10'h040, 1'b1, 5'h1f}) $display("FAIL halt_br_setup: got %h/%b/%h want 040/1/1f", fetch_pc, fetch_valid, instr_mem_out[15:11]); else n_pass++;
    tick(1, 10'h100, 0);
    n_tot++; if ({halted, instr_mem_addr} !== {1'b0, 10'h100}) $display("FAIL halt_br_drop: got %b/%h want 0/100", halted, instr_mem_addr); else n_pass++;
    mem[10'h040] = 16'h0000;
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    tick(0, '0, 0);
    tick(1, 10'h3FE, 0);
    tick(0, '0, 0);
    n_tot++; if ({instr_mem_addr, pc_wrapped} !== {10'h3FF, 1'b0}) $display("FAIL wrap_pre: got %h/%b want 3ff/0", instr_mem_addr, pc_wrapped); else n_pass++;
    tick(0, '0, 0);
    n_tot++; if ({instr_mem_addr, pc_wrapped} !== {10'h000, 1'b1}) $display("FAIL wrap_post: got %h/%b want 000/1", instr_mem_addr, pc_wrapped); else n_pass++;
    tick(1, 10'h010, 0);
    tick(0, '0, 1);
    tick(0, '0, 1);
    n_tot++; if ({pc_wrapped, instr_mem_addr} !== {1'b1, 10'h010}) $display("FAIL wrap_sticky: got %b/%h want 1/010", pc_wrapped, instr_mem_addr); else n_pass++;
    #2 rst = 0; #1;
    n_tot++; if ({instr_mem_addr, fetch_pc, instr_mem_rd_en, fetch_valid, halted, pc_wrapped} !== 24'h0) $display("FAIL midstall_rst: got %h/%h/%b%b%b%b want 0/0/0000", instr_mem_addr, fetch_pc, instr_mem_rd_en, fetch_valid, halted, pc_wrapped); else n_pass++;
    n_tot++; if ({fetch_cnt, flush_cnt} !== 24'h0) $display("FAIL midstall_rst_cnt: got %h/%h want 0/0", fetch_cnt, flush_cnt); else n_pass++;
    @(posedge clk); #1 rst = 1;
  endtask

  task automatic test_flush_sat();
    do_reset();
    for (int i = 0; i < 262; i++) tick(1, W'($urandom), 0);
    n_tot++; if (flush_cnt !== (PERF ? 8'hFF : 8'h00)) $display("FAIL flush_sat: got %0d want %0d", flush_cnt, PERF ? 255 : 0); else n_pass++;
  endtask

  task automatic test_random();
    logic [W+3:0] act, exp;
    fill_mem(4);
    do_reset();
    for (int c = 0; c < 600; c++) begin
      tick($urandom_range(99) < 6, W'($urandom), $urandom_range(99) < 25);
      act = {instr_mem_addr, instr_mem_rd_en, fetch_valid, halted, pc_wrapped};
      exp = {m_pc, m_run && !m_halt, m_valid, m_halt, m_wrap};
      n_tot++; if (act !== exp) $display("FAIL rand_ctrl c%0d: got %h want %h", c, act, exp); else n_pass++;
      if (m_valid) begin
        n_tot++; if (fetch_pc !== m_fpc) $display("FAIL rand_fpc c%0d: got %h want %h", c, fetch_pc, m_fpc); else n_pass++;
      end
      n_tot++; if ({fetch_cnt, flush_cnt} !== {PERF ? 16'(m_fcnt) : 16'h0, PERF ? 8'(m_flcnt) : 8'h0}) $display("FAIL rand_cnt c%0d: got %0d/%0d want %0d/%0d", c, fetch_cnt, flush_cnt, PERF ? m_fcnt : 0, PERF ? m_flcnt : 0); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_branch();
    test_stall();
    test_halt();
    test_wrap_and_reset();
    test_flush_sat();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got %0d/%0d", n_pass, n_tot);
    $fatal(1);
  end
endmodule
